// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
//   alu_ctrl_e  : decoded 5-bit ALU operation
//   ALUOP_*     : encodings of the 2-bit alu_op field from the main decoder
//   F7_*        : funct7 values that select base / alternate / mul-div groups
//   alu_state_e : handshake/iteration FSM states
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD     = 5'd0,
        ALU_SUB     = 5'd1,
        ALU_SLL     = 5'd2,
        ALU_SLT     = 5'd3,
        ALU_SLTU    = 5'd4,
        ALU_XOR     = 5'd5,
        ALU_SRL     = 5'd6,
        ALU_SRA     = 5'd7,
        ALU_OR      = 5'd8,
        ALU_AND     = 5'd9,
        ALU_MUL     = 5'd10,
        ALU_MULH    = 5'd11,
        ALU_MULHSU  = 5'd12,
        ALU_MULHU   = 5'd13,
        ALU_DIV     = 5'd14,
        ALU_DIVU    = 5'd15,
        ALU_REM     = 5'd16,
        ALU_REMU    = 5'd17,
        ALU_ILLEGAL = 5'd18
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

    // Base integer funct3 map (funct7 = 0000000 flavour).
    function automatic alu_ctrl_e base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ILLEGAL;
        endcase
    endfunction

    // M-extension funct3 map.
    function automatic alu_ctrl_e muldiv_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            3'b111:  return ALU_REMU;
            default: return ALU_ILLEGAL;
        endcase
    endfunction

    function automatic logic is_mul_op(input alu_ctrl_e op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_div_op(input alu_ctrl_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALU control decoder, reusable by the hazard unit.
//   alu_op   : 2-bit class from the main decoder (add / sub / R-type / I-type)
//   funct7   : instruction funct7 field
//   funct3   : instruction funct3 field
//   alu_ctrl : decoded operation, ALU_ILLEGAL for any undecodable encoding
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int MUL_ENABLE = 1
) (
    input  logic [1:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output alu_ctrl_e  alu_ctrl
);

    // Map (alu_op, funct7, funct3) onto a single ALU operation.
    always_comb begin
        alu_ctrl = ALU_ILLEGAL;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    alu_ctrl = base_op(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        alu_ctrl = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        alu_ctrl = ALU_SRA;
                    end else begin
                        alu_ctrl = ALU_ILLEGAL;
                    end
                end else if ((funct7 == F7_MULDIV) && (MUL_ENABLE != 0)) begin
                    alu_ctrl = muldiv_op(funct3);
                end else begin
                    alu_ctrl = ALU_ILLEGAL;
                end
            end
            ALUOP_ITYPE: begin
                // Immediates carry no funct7 except for the shift encodings.
                case (funct3)
                    3'b001: alu_ctrl = (funct7 == F7_BASE) ? ALU_SLL : ALU_ILLEGAL;
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            alu_ctrl = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            alu_ctrl = ALU_SRA;
                        end else begin
                            alu_ctrl = ALU_ILLEGAL;
                        end
                    end
                    default: alu_ctrl = base_op(funct3);
                endcase
            end
            default: alu_ctrl = ALU_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I ops, iterative RV32M mul/div/rem.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : request handshake from ID/EX
//   alu_op, funct7/3     : encoding to decode
//   op_a, op_b           : operands (rs1, rs2/imm)
//   out_valid / out_ready: result handshake towards EX/MEM
//   result, illegal      : result and undecodable flag, held while out_valid
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_ENABLE = 1,
    parameter int SHAMT_W    = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_ctrl_e         ctrl_s;
    logic              accept_s, ovf_s, fast_div_s, iter_s;
    logic              a_neg_s, b_neg_s, neg_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, quick_s, final_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] step_s, prod_s;

    alu_state_e        state_r, state_n;
    alu_ctrl_e         op_r, op_n;
    logic              neg_r, neg_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    // acc_r = {hi, lo}: product accumulator, or {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc_r, acc_n;
    logic [XLEN-1:0]   opnd_r, opnd_n;
    logic [XLEN-1:0]   result_r, result_n;
    logic              illegal_r, illegal_n;

    alu_ctrl_decode #(.MUL_ENABLE(MUL_ENABLE)) u_decode (
        .alu_op   (alu_op),
        .funct7   (funct7),
        .funct3   (funct3),
        .alu_ctrl (ctrl_s)
    );

    assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_RESP) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == ST_RESP);
    assign result    = result_r;
    assign illegal   = illegal_r;
    assign shamt_s   = op_b[SHAMT_W-1:0];

    // Operand signs, magnitudes and fast-path detection for M-extension ops.
    always_comb begin
        a_neg_s = ((ctrl_s == ALU_MULH) || (ctrl_s == ALU_MULHSU) ||
                   (ctrl_s == ALU_DIV)  || (ctrl_s == ALU_REM)) && op_a[XLEN-1];
        b_neg_s = ((ctrl_s == ALU_MULH) || (ctrl_s == ALU_DIV) ||
                   (ctrl_s == ALU_REM)) && op_b[XLEN-1];
        // Remainder takes the dividend's sign; everything else the xor.
        neg_s      = (ctrl_s == ALU_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
        mag_a_s    = a_neg_s ? (-op_a) : op_a;
        mag_b_s    = b_neg_s ? (-op_b) : op_b;
        ovf_s      = ((ctrl_s == ALU_DIV) || (ctrl_s == ALU_REM)) &&
                     (op_a == MIN_NEG) && (op_b == {XLEN{1'b1}});
        fast_div_s = is_div_op(ctrl_s) && ((op_b == {XLEN{1'b0}}) || ovf_s);
        iter_s     = is_mul_op(ctrl_s) || (is_div_op(ctrl_s) && !fast_div_s);
    end

    // Single-cycle result, including divide-by-zero and overflow fast paths.
    always_comb begin
        quick_s = {XLEN{1'b0}};
        case (ctrl_s)
            ALU_ADD:  quick_s = op_a + op_b;
            ALU_SUB:  quick_s = op_a - op_b;
            ALU_SLL:  quick_s = op_a << shamt_s;
            ALU_SLT:  quick_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: quick_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  quick_s = op_a ^ op_b;
            ALU_SRL:  quick_s = op_a >> shamt_s;
            ALU_SRA:  quick_s = $unsigned($signed(op_a) >>> shamt_s);
            ALU_OR:   quick_s = op_a | op_b;
            ALU_AND:  quick_s = op_a & op_b;
            ALU_DIV:  quick_s = (op_b == {XLEN{1'b0}}) ? {XLEN{1'b1}} : op_a;
            ALU_DIVU: quick_s = {XLEN{1'b1}};
            ALU_REM:  quick_s = (op_b == {XLEN{1'b0}}) ? op_a : {XLEN{1'b0}};
            ALU_REMU: quick_s = op_a;
            default:  quick_s = {XLEN{1'b0}};
        endcase
    end

    // One iteration: shift-add multiply or restoring divide step.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_shift_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (is_mul_op(op_r)) begin
            step_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end else if (!div_diff_s[XLEN]) begin
            step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            step_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up and field selection after the last iteration.
    always_comb begin
        prod_s = neg_r ? (-step_s) : step_s;
        case (op_r)
            ALU_MUL:                         final_s = prod_s[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: final_s = prod_s[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               final_s = neg_r ? (-step_s[XLEN-1:0]) : step_s[XLEN-1:0];
            ALU_REM, ALU_REMU:               final_s = neg_r ? (-step_s[2*XLEN-1:XLEN]) : step_s[2*XLEN-1:XLEN];
            default:                         final_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state and datapath-register logic.
    always_comb begin
        state_n   = state_r;
        op_n      = op_r;
        neg_n     = neg_r;
        cnt_n     = cnt_r;
        acc_n     = acc_r;
        opnd_n    = opnd_r;
        result_n  = result_r;
        illegal_n = illegal_r;
        case (state_r)
            ST_IDLE: state_n = ST_IDLE;
            ST_BUSY: begin
                acc_n = step_s;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_n   = ST_RESP;
                    result_n  = final_s;
                    illegal_n = 1'b0;
                end else begin
                    cnt_n = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Acceptance only happens in IDLE or RESP, so it overrides the above.
        if (accept_s) begin
            op_n  = ctrl_s;
            neg_n = neg_s;
            if (iter_s) begin
                state_n   = ST_BUSY;
                cnt_n     = CNT_W'(XLEN-1);
                acc_n     = {{XLEN{1'b0}}, mag_a_s};
                opnd_n    = mag_b_s;
                result_n  = {XLEN{1'b0}};
                illegal_n = 1'b0;
            end else begin
                state_n   = ST_RESP;
                result_n  = quick_s;
                illegal_n = (ctrl_s == ALU_ILLEGAL);
            end
        end else begin
            op_n = op_n;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= ALU_ADD;
            neg_r     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            result_r  <= {XLEN{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            op_r      <= op_n;
            neg_r     <= neg_n;
            cnt_r     <= cnt_n;
            acc_r     <= acc_n;
            opnd_r    <= opnd_n;
            result_r  <= result_n;
            illegal_r <= illegal_n;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32), plus a second
// instance with MUL_ENABLE=0 to check that M-extension encodings are illegal.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        illegal;

    logic        nm_in_valid, nm_in_ready, nm_out_valid, nm_out_ready, nm_illegal;
    logic [31:0] nm_result;

    int n_cmp;
    int n_fail;

    alu_exec_unit #(.XLEN(32), .MUL_ENABLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
    );

    alu_exec_unit #(.XLEN(32), .MUL_ENABLE(0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(nm_out_valid), .out_ready(nm_out_ready), .result(nm_result), .illegal(nm_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for out_valid (bounded), check latency/result/illegal.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        int lat;
        @(negedge clk);
        alu_op = aop; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    endtask

    initial begin
        int stale;
        logic [31:0] held;
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; nm_in_valid = 1'b0;
        out_ready = 1'b1; nm_out_ready = 1'b1;
        alu_op = 2'b00; funct7 = 7'b0; funct3 = 3'b0; op_a = 32'h0; op_b = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", {31'b0, out_valid}, 32'h0);
        check("rst result", result, 32'h0);
        check("rst illegal", {31'b0, illegal}, 32'h0);
        check("rst in_ready", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle sweep, op_a = 0xFFFF_FFF0, op_b = 4
        run_op("SUB",    2'b01, 7'b0000000, 3'b000, 32'hFFFF_FFF0, 32'h4, 32'hFFFF_FFEC, 1'b0, 1);
        run_op("SRAI",   2'b11, 7'b0100000, 3'b101, 32'hFFFF_FFF0, 32'h4, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("SRL",    2'b10, 7'b0000000, 3'b101, 32'hFFFF_FFF0, 32'h4, 32'h0FFF_FFFF, 1'b0, 1);
        run_op("SLT",    2'b10, 7'b0000000, 3'b010, 32'hFFFF_FFF0, 32'h4, 32'h0000_0001, 1'b0, 1);
        run_op("SLTU",   2'b10, 7'b0000000, 3'b011, 32'hFFFF_FFF0, 32'h4, 32'h0000_0000, 1'b0, 1);
        run_op("ADDI f7 ignored", 2'b11, 7'b0100000, 3'b000, 32'hFFFF_FFF0, 32'h4, 32'hFFFF_FFF4, 1'b0, 1);
        run_op("SLL",    2'b10, 7'b0000000, 3'b001, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, 1);

        // Iterative multiply / divide
        run_op("MULH",   2'b10, 7'b0000001, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        run_op("DIV",    2'b10, 7'b0000001, 3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("REM",    2'b10, 7'b0000001, 3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("MUL",    2'b10, 7'b0000001, 3'b000, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFF1, 1'b0, 33);
        run_op("MULHU",  2'b10, 7'b0000001, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("DIVU",   2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33);

        // Fast-path corners
        run_op("DIVU by 0", 2'b10, 7'b0000001, 3'b101, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("REM ovf",   2'b10, 7'b0000001, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        run_op("DIV ovf",   2'b10, 7'b0000001, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);

        // Illegal encodings
        run_op("ILL R f7alt f3 111", 2'b10, 7'b0100000, 3'b111, 32'h5, 32'h3, 32'h0, 1'b1, 1);
        run_op("ILL SLLI f7alt",     2'b11, 7'b0100000, 3'b001, 32'h5, 32'h3, 32'h0, 1'b1, 1);

        // MUL_ENABLE=0 instance with a MUL encoding
        @(negedge clk);
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000; op_a = 32'h6; op_b = 32'h7;
        nm_in_valid = 1'b1;
        @(posedge clk); #1;
        nm_in_valid = 1'b0;
        check("nomul out_valid", {31'b0, nm_out_valid}, 32'h1);
        check("nomul illegal", {31'b0, nm_illegal}, 32'h1);
        check("nomul result", nm_result, 32'h0);

        // Handshake: hold out_ready low in RESP, then back-to-back accept
        @(negedge clk);
        out_ready = 1'b0;
        alu_op = 2'b10; funct7 = 7'b0000000; funct3 = 3'b100;
        op_a = 32'hF0F0_0000; op_b = 32'h0F0F_00FF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        held = 32'hFFFF_00FF;
        check("hold XOR result", result, held);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hold result stable", result, held);
            check("hold out_valid", {31'b0, out_valid}, 32'h1);
            check("hold in_ready", {31'b0, in_ready}, 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        alu_op = 2'b00; funct7 = 7'b0; funct3 = 3'b0; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
        #1;
        check("b2b in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b out_valid", {31'b0, out_valid}, 32'h1);
        check("b2b result", result, 32'd7);

        // Reset mid-BUSY: DIVU 100/7, reset asserted on cycle 5
        @(negedge clk);
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {31'b0, out_valid}, 32'h0);
        check("midrst result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst in_ready", {31'b0, in_ready}, 32'h1);
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("midrst no stale result", 32'(stale), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU with a built-in control decoder.
- Decodes ALUOp/funct7/funct3 into a 5-bit operation, executes RV32I integer ops in one cycle and RV32M mul/div/rem iteratively.
- Returns results over a valid/ready handshake; sits between the ID/EX register and the EX/MEM register, stalling the pipeline via in_ready.
- Illegal encodings are flagged and produce a defined zero result, never X.

Parameters:
- XLEN, 32: operand/result width; must be a power of two ≥ 8.
- MUL_ENABLE, 1: 1 = M-extension ops execute; 0 = M-extension ops flagged illegal.
- SHAMT_W, $clog2(XLEN): shift-amount width, taken from op_b LSBs.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: request valid.
- in_ready, out, 1: unit can accept a request this cycle.
- alu_op, in, 2: 00 = add (load/store address), 01 = sub (branch), 10 = R-type, 11 = I-type ALU.
- funct7, in, 7: instruction funct7 field.
- funct3, in, 3: instruction funct3 field.
- op_a, in, XLEN: operand A (rs1).
- op_b, in, XLEN: operand B (rs2 or immediate).
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- result, out, XLEN: ALU result.
- illegal, out, 1: qualified by out_valid; the encoding was not decodable.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, illegal=0, iteration counter=0, internal operand registers=0. Assertion mid-operation aborts the operation; no result is ever produced for it.
- Decode rules:
  - alu_op 00 → ADD. alu_op 01 → SUB.
  - alu_op 10, funct7 0000000 → funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - alu_op 10, funct7 0100000 → funct3 000 SUB, 101 SRA.
  - alu_op 10, funct7 0000001 → MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 0..7).
  - alu_op 11 → same funct3 map, funct7 ignored, except: funct3 001 requires funct7=0000000; funct3 101 uses funct7 0000000 for SRL and 0100000 for SRA.
  - Everything else is illegal.
- Shifts use op_b[SHAMT_W-1:0]. SLT is signed, SLTU unsigned; both give a 0/1 result, zero-extended.
- FSM states: IDLE, BUSY, RESP.
- in_ready = (state==IDLE) || (state==RESP && out_ready). A request is accepted when in_valid && in_ready.
- Single-cycle op or illegal: accept → RESP on the next edge, result registered. Latency is 1 cycle.
- Mul/div op: accept → BUSY, counter=XLEN-1.
  - Multiply: shift-add over a 2·XLEN product.
  - Divide: restoring division on magnitudes, with sign fix-up.
  - One bit per cycle; BUSY→RESP when counter==0. Latency to out_valid is XLEN+1 cycles.
- Fast-path mul/div cases complete in 1 cycle, with no BUSY:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = op_a.
  - Signed overflow (op_a = -2^(XLEN-1), op_b = -1): DIV = op_a, REM = 0.
- RESP:
  - out_valid=1; result and illegal are held stable until out_ready.
  - out_ready && !in_valid → IDLE, out_valid=0.
  - out_ready && in_valid → back-to-back accept of the new request, which enters RESP or BUSY per its op.
- In IDLE and BUSY, out_valid=0. In_valid during BUSY is ignored, because in_ready=0.
- MUL_ENABLE=0: funct7 0000001 with alu_op 10 → illegal=1, result=0, 1-cycle.
- All arithmetic wraps modulo 2^XLEN. MULH* return the upper XLEN bits of the signed/unsigned/mixed product.

Decomposition:
- Package alu_pkg:
  - alu_ctrl_e: 5-bit enum ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, ILLEGAL.
  - ALUOP_* constants for the 2-bit alu_op field.
  - F7_BASE=0000000, F7_ALT=0100000, F7_MULDIV=0000001.
  - FSM state enum.
- Sub-module alu_ctrl_decode: purely combinational; (alu_op, funct7, funct3, MUL_ENABLE) → alu_ctrl_e. It is instantiated once here and is reusable by the hazard unit.

Test Plan:
- Reset mid-BUSY: start DIVU 100/7, drop rst_n on cycle 5 → out_valid=0 and result=0 immediately; after release, in_ready=1 and no stale result appears.
- Single-cycle decode sweep, XLEN=32, op_a=0xFFFF_FFF0, op_b=0x0000_0004:
  - SUB → 0xFFFF_FFEC; SRA (I-type, funct7 0100000) → 0xFFFF_FFFF; SRL → 0x0FFF_FFFF; SLT → 1; SLTU → 0.
  - Each has out_valid exactly 1 cycle after accept.
- Iterative ops:
  - MULH op_a=0x8000_0000, op_b=0x8000_0000 → 0x4000_0000.
  - DIV -7/2 → 0xFFFF_FFFD.
  - REM -7/2 → 0xFFFF_FFFF.
  - out_valid asserts exactly 33 cycles after accept.
- Corner cases:
  - DIVU x/0 → 0xFFFF_FFFF in 1 cycle.
  - REM 0x8000_0000/-1 → 0.
  - DIV 0x8000_0000/-1 → 0x8000_0000.
- Handshake: hold out_ready=0 for 4 cycles in RESP → result stable, in_ready=0. Then out_ready=1 with in_valid=1 (ADD 3+4) → back-to-back accept, and 7 is presented next cycle.
- Illegal encodings:
  - alu_op 10, funct7 0100000, funct3 111 → illegal=1, result=0.
  - MUL_ENABLE=0 with a MUL encoding → illegal=1.
